// File: rtl/fb_port_arbiter.sv
// Frame-RAM port arbiter.
// Shares one single-port frame RAM between the VGA scan-out reader, a pixel
// write stream and an internal clear engine. Reads always win. Clear writes
// and stream writes use the idle cycles. The stream write address is generated
// here. It auto-increments, wraps at the end of the frame and is resynced by
// SOF, so writers only have to push pixels.
// The RAM samples we/re/adr/dat on the rising edge and has 1-cycle read
// latency, so the grant logic below is purely combinational.

module fb_port_arbiter #(
  parameter int DEPTH = 307200,
  parameter int AW    = 19,
  parameter int DW    = 12
) (
  input  logic          clk_i,
  input  logic          rst,

  // VGA scan-out read port
  input  logic          rd_req,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat,
  output logic          rd_vld,

  // Pixel write stream
  input  logic          wr_valid,
  input  logic          wr_sof,
  input  logic [DW-1:0] wr_dat,
  output logic          wr_ready,

  // Clear engine control
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          busy,
  output logic          clr_done,

  // Stream frame status
  output logic          frame_done,
  output logic [7:0]    frame_cnt,

  // Frame RAM port
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_wdat,
  input  logic [DW-1:0] ram_rdat
);

  // Pointer limits are derived from DEPTH, not from 2^AW-1, because DEPTH is
  // normally not a power of two.
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);
  // After an SOF pixel at address 0, the next pixel goes to address 1. A
  // one-word RAM would wrap straight back to 0.
  localparam logic [AW-1:0] SOF_NEXT = (DEPTH > 1) ? AW'(1) : '0;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]    state_q,      state_d;
  logic [AW-1:0] wptr_q,       wptr_d;
  logic [AW-1:0] cptr_q,       cptr_d;
  logic [DW-1:0] color_q,      color_d;
  logic          rd_vld_q;
  logic          clr_done_q,   clr_done_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q,  frame_cnt_d;

  logic in_idle;
  logic in_clear;
  logic clr_gnt;
  logic wr_gnt;
  logic clr_last;
  logic wr_last;
  logic clr_accept;

  // Fixed-priority grant: read, then clear, then stream.
  assign in_idle    = (state_q == S_IDLE);
  assign in_clear   = (state_q == S_CLEAR);
  assign clr_gnt    = ~rd_req & in_clear;
  assign wr_gnt     = ~rd_req & in_idle & wr_valid;
  assign clr_last   = clr_gnt & (cptr_q == LAST_ADR);
  assign wr_last    = wr_gnt & ~wr_sof & (wptr_q == LAST_ADR);
  // A start request that arrives during a clear is dropped.
  assign clr_accept = in_idle & clr_start;

  assign wr_ready   = in_idle & ~rd_req;
  assign rd_dat     = ram_rdat;
  assign rd_vld     = rd_vld_q;
  assign busy       = in_clear;
  assign clr_done   = clr_done_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Drive the RAM port from whichever source holds the grant this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first. A
    // path that leaves a signal unassigned would infer a latch.
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_adr  = '0;
    ram_wdat = '0;
    if (rd_req) begin
      ram_re  = 1'b1;
      ram_adr = rd_adr;
    end else if (in_clear) begin
      ram_we   = 1'b1;
      ram_adr  = cptr_q;
      ram_wdat = color_q;
    end else if (wr_gnt) begin
      ram_we   = 1'b1;
      ram_adr  = wr_sof ? '0 : wptr_q;
      ram_wdat = wr_dat;
    end
  end

  // Next state for the IDLE/CLEAR controller and the clear pointer and colour.
  // A clear write blocked by a read leaves cptr unchanged, so that address is
  // retried on the next cycle.
  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    color_d = color_q;
    if (clr_accept) begin
      state_d = S_CLEAR;
      cptr_d  = '0;
      color_d = clr_color;
    end else if (clr_gnt) begin
      if (clr_last) begin
        state_d = S_IDLE;
        cptr_d  = '0;
      end else begin
        cptr_d  = cptr_q + AW'(1);
      end
    end
  end

  // Next stream write pointer. SOF resyncs the pointer to address 0. The end
  // of a frame wraps the pointer. Finishing a clear rewinds it so that the
  // next frame starts at address 0.
  always_comb begin
    wptr_d = wptr_q;
    if (clr_last) begin
      wptr_d = '0;
    end else if (wr_gnt) begin
      if (wr_sof) begin
        wptr_d = SOF_NEXT;
      end else if (wr_last) begin
        wptr_d = '0;
      end else begin
        wptr_d = wptr_q + AW'(1);
      end
    end
  end

  // Completion pulses fire on the cycle after the write that finishes the
  // clear or the frame.
  always_comb begin
    clr_done_d   = clr_last;
    frame_done_d = wr_last;
    frame_cnt_d  = frame_cnt_q + 8'(wr_last);
  end

  // State and status registers, cleared by the synchronous active-high reset.
  // A reset during a clear returns the block to IDLE with no clr_done pulse.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge no matter which statement
    // order is used.
    if (rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      cptr_q       <= '0;
      color_q      <= '0;
      rd_vld_q     <= 1'b0;
      clr_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cptr_q       <= cptr_d;
      color_q      <= color_d;
      rd_vld_q     <= rd_req;
      clr_done_q   <= clr_done_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter.
// The main instance uses DEPTH=16 and is wired to a small behavioural RAM.
// A second instance uses DEPTH=20, which is not a power of two, to cover the
// frame wrap.

module tb_fb_port_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int DW    = 12;

  logic          clk_i = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_adr;
  logic [DW-1:0] rd_dat;
  logic          rd_vld;
  logic          wr_valid;
  logic          wr_sof;
  logic [DW-1:0] wr_dat;
  logic          wr_ready;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          busy;
  logic          clr_done;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat;

  // Second instance, DEPTH=20: only the stream path is exercised
  logic          w2_valid;
  logic          w2_sof;
  logic [DW-1:0] w2_dat;
  logic          w2_ready;
  logic [DW-1:0] r2_dat;
  logic          r2_vld;
  logic          b2_busy;
  logic          b2_done;
  logic          fd2;
  logic [7:0]    fc2;
  logic          r2_we;
  logic          r2_re;
  logic [AW-1:0] r2_adr;
  logic [DW-1:0] r2_wdat;
  logic          tie0 = 1'b0;
  logic [AW-1:0] tie_adr = '0;
  logic [DW-1:0] tie_dat = '0;

  always #5 clk_i = ~clk_i;

  fb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst(rst),
    .rd_req(rd_req), .rd_adr(rd_adr), .rd_dat(rd_dat), .rd_vld(rd_vld),
    .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_dat(wr_dat), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_color(clr_color), .busy(busy), .clr_done(clr_done),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .ram_we(ram_we), .ram_re(ram_re), .ram_adr(ram_adr), .ram_wdat(ram_wdat),
    .ram_rdat(ram_rdat)
  );

  fb_port_arbiter #(.DEPTH(20), .AW(AW), .DW(DW)) dut20 (
    .clk_i(clk_i), .rst(rst),
    .rd_req(tie0), .rd_adr(tie_adr), .rd_dat(r2_dat), .rd_vld(r2_vld),
    .wr_valid(w2_valid), .wr_sof(w2_sof), .wr_dat(w2_dat), .wr_ready(w2_ready),
    .clr_start(tie0), .clr_color(tie_dat), .busy(b2_busy), .clr_done(b2_done),
    .frame_done(fd2), .frame_cnt(fc2),
    .ram_we(r2_we), .ram_re(r2_re), .ram_adr(r2_adr), .ram_wdat(r2_wdat),
    .ram_rdat(tie_dat)
  );

  // Behavioural frame RAM with a write log
  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } wr_t;

  logic [DW-1:0] mem [0:31];
  wr_t           wlog [$];
  int            both_cnt = 0;

  always @(posedge clk_i) begin
    if (ram_we) begin
      mem[ram_adr] <= ram_wdat;
      wlog.push_back('{adr: ram_adr, dat: ram_wdat});
    end
    if (ram_re) ram_rdat <= mem[ram_adr];
    if (ram_we && ram_re) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one stream pixel and check where it lands in the cycle it is granted
  task automatic push(input logic sof, input logic [DW-1:0] dat, input int exp_adr);
    wr_valid = 1'b1;
    wr_sof   = sof;
    wr_dat   = dat;
    #1;
    check("push_ready", 32'(wr_ready), 32'd1);
    check("push_adr", 32'(ram_adr), 32'(exp_adr));
    step();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  initial begin
    int n_done;
    bit finished;

    rst = 1'b1; rd_req = 1'b0; rd_adr = '0; wr_valid = 1'b0; wr_sof = 1'b0;
    wr_dat = '0; clr_start = 1'b0; clr_color = '0;
    w2_valid = 1'b0; w2_sof = 1'b0; w2_dat = '0; ram_rdat = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    step();
    step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_ram_port", {29'd0, ram_we, ram_re, |ram_adr}, 32'd0);

    // 1: a full frame of 16 pixels, with SOF on the first pixel
    wlog.delete();
    for (int i = 0; i < DEPTH; i++) begin
      push(i == 0, DW'(i + 1), i);
      check("t1_frame_done", 32'(frame_done), 32'(i == DEPTH - 1));
    end
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    step();
    check("t1_done_one_pulse", 32'(frame_done), 32'd0);
    check("t1_nwrites", 32'(wlog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("t1_order_adr", 32'(wlog[i].adr), 32'(i));
      check("t1_order_dat", 32'(wlog[i].dat), 32'(i + 1));
    end

    // 2: three reads override a waiting stream pixel
    wr_valid = 1'b1; wr_sof = 1'b0; wr_dat = 12'h111;
    for (int k = 0; k < 3; k++) begin
      rd_req = 1'b1;
      rd_adr = AW'(2 + k);
      #1;
      check("t2_wr_ready", 32'(wr_ready), 32'd0);
      check("t2_ram_re_we", {30'd0, ram_re, ram_we}, 32'd2);
      check("t2_ram_adr", 32'(ram_adr), 32'(2 + k));
      step();
      check("t2_rd_vld", 32'(rd_vld), 32'd1);
      check("t2_rd_dat", 32'(rd_dat), 32'(3 + k));
    end
    rd_req = 1'b0;
    #1;
    check("t2_resume_ready", 32'(wr_ready), 32'd1);
    check("t2_resume_adr", 32'(ram_adr), 32'd0);
    step();
    wr_valid = 1'b0;
    check("t2_rd_vld_off", 32'(rd_vld), 32'd0);
    check("t2_mem0", 32'(mem[0]), 32'h111);

    // 3: clear to 0xF00 while the reader takes every other cycle
    clr_color = 12'hF00; clr_start = 1'b1;
    step();
    clr_start = 1'b0; clr_color = 12'h000;
    wlog.delete();
    check("t3_busy", 32'(busy), 32'd1);
    n_done = 0;
    finished = 1'b0;
    for (int c = 0; c < 80 && !finished; c++) begin
      rd_req = c[0];
      rd_adr = AW'(3);
      #1;
      if (c == 0) check("t3_wr_stalled", 32'(wr_ready), 32'd0);
      step();
      if (clr_done) n_done++;
      if (!busy) finished = 1'b1;
    end
    rd_req = 1'b0;
    check("t3_finished", 32'(finished), 32'd1);
    check("t3_done_pulses", 32'(n_done), 32'd1);
    step();
    check("t3_done_cleared", 32'(clr_done), 32'd0);
    check("t3_nwrites", 32'(wlog.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < wlog.size(); i++) begin
      check("t3_clr_adr", 32'(wlog[i].adr), 32'(i));
      check("t3_clr_dat", 32'(wlog[i].dat), 32'hF00);
    end
    rd_req = 1'b1; rd_adr = AW'(5);
    step();
    check("t3_read5", 32'(rd_dat), 32'hF00);
    rd_adr = AW'(15);
    step();
    rd_req = 1'b0;
    check("t3_read15", 32'(rd_dat), 32'hF00);
    // The write pointer was 1 before the clear and must restart at 0
    push(1'b0, 12'h200, 0);

    // 4: an SOF pixel in the middle of a frame
    for (int i = 0; i < 5; i++) push(1'b0, DW'(12'h301 + i), i + 1);
    push(1'b1, 12'hABC, 0);
    push(1'b0, 12'h222, 1);
    check("t4_no_frame_done", 32'(frame_done), 32'd0);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t4_mem0", 32'(mem[0]), 32'hABC);
    check("t4_mem1", 32'(mem[1]), 32'h222);

    // 5: reset while the clear is about to write address 7
    clr_color = 12'h0F0; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t5_at_cptr7", {26'd0, ram_we, ram_adr}, {26'd0, 1'b1, 5'd7});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_clr_done", 32'(clr_done), 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_wr_ready", 32'(wr_ready), 32'd1);
    step();
    check("t5_clr_done_later", 32'(clr_done), 32'd0);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    check("t5_restart_adr", {26'd0, ram_we, ram_adr}, {26'd0, 1'b1, 5'd0});
    n_done = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      step();
      if (clr_done) n_done++;
    end
    check("t5_restart_done", {30'd0, busy, 1'b0} | 32'(n_done), 32'd1);

    // 6: DEPTH=20, a full frame plus one pixel
    for (int i = 0; i <= 20; i++) begin
      w2_valid = 1'b1; w2_sof = (i == 0); w2_dat = DW'(i);
      #1;
      check("t6_adr", 32'(r2_adr), (i == 20) ? 32'd0 : 32'(i));
      check("t6_we", 32'(r2_we), 32'd1);
      step();
      check("t6_frame_done", 32'(fd2), 32'(i == 19));
    end
    w2_valid = 1'b0; w2_sof = 1'b0;
    check("t6_frame_cnt", 32'(fc2), 32'd1);

    check("we_re_exclusive", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
